// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with HI/LO registers; define MDU_DIV_EN to add div/divu
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins_D,
  input  logic [31:0] ins_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] MC = 4'(MULT_CYC - 1);
  localparam logic [3:0] DC = 4'(DIV_CYC - 1);
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo, nxt_hi, nxt_lo;
  logic [63:0] a64, b64, prod;
  logic        e_r, e_mult, e_multu, e_div, e_divu, e_mthi, e_mtlo, d_md;
  logic        unused_bits;
  assign unused_bits = ^{ins_E[25:6], ins_D[25:6]};
  assign e_r     = ins_E[31:26] == 6'd0;
  assign e_mult  = e_r && ins_E[5:0] == 6'h18;
  assign e_multu = e_r && ins_E[5:0] == 6'h19;
  assign e_mthi  = e_r && ins_E[5:0] == 6'h11;
  assign e_mtlo  = e_r && ins_E[5:0] == 6'h13;
  assign a64  = {{32{e_mult & rs_E[31]}}, rs_E};
  assign b64  = {{32{e_mult & rt_E[31]}}, rt_E};
  assign prod = a64 * b64;
`ifdef MDU_DIV_EN
  logic [31:0] dvs, qs, rms, qu, ru;
  assign e_div  = e_r && ins_E[5:0] == 6'h1a;
  assign e_divu = e_r && ins_E[5:0] == 6'h1b;
  assign d_md   = ins_D[31:26] == 6'd0 && (ins_D[5:2] == 4'b0110 || ins_D[5:2] == 4'b0100);
  assign dvs    = rt_E == 32'd0 ? 32'd1 : rt_E;
  assign qs     = $signed(rs_E) / $signed(dvs);
  assign rms    = $signed(rs_E) % $signed(dvs);
  assign qu     = rs_E / dvs;
  assign ru     = rs_E % dvs;
  assign nxt_hi = (e_div | e_divu) ? (rt_E == 32'd0 ? hi : e_div ? rms : ru) : prod[63:32];
  assign nxt_lo = (e_div | e_divu) ? (rt_E == 32'd0 ? lo : e_div ? qs : qu) : prod[31:0];
`else
  assign e_div  = 1'b0;
  assign e_divu = 1'b0;
  assign d_md   = ins_D[31:26] == 6'd0 && (ins_D[5:1] == 5'b01100 || ins_D[5:2] == 4'b0100);
  assign nxt_hi = prod[63:32];
  assign nxt_lo = prod[31:0];
`endif
  assign start    = state == IDLE && (e_mult | e_multu | e_div | e_divu);
  assign busy     = state == BUSY;
  assign stall_md = d_md && (start | busy);
  // FSM: capture result on start, count down, commit to HI/LO when cnt hits zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state  <= BUSY;
        cnt    <= (e_mult | e_multu) ? MC : DC;
        res_hi <= nxt_hi;
        res_lo <= nxt_lo;
      end else begin
        if (e_mthi) hi <= rs_E;
        if (e_mtlo) lo <= rs_E;
      end
    end else if (cnt == 4'd0) begin
      state <= IDLE;
      hi    <= res_hi;
      lo    <= res_lo;
    end else cnt <= cnt - 4'd1;
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
  localparam logic [31:0] NOP = 32'h0, MULT = 32'h18, MULTU = 32'h19, DIV = 32'h1a, DIVU = 32'h1b;
  localparam logic [31:0] MFHI = 32'h10, MTHI = 32'h11, MFLO = 32'h12, MTLO = 32'h13;
  logic clk = 1'b0, reset;
  logic [31:0] ins_D, ins_E, rs_E, rt_E, hi, lo;
  logic start, busy, stall_md;
  int total = 0, bad = 0;
  mdu_ctrl dut (.clk(clk), .reset(reset), .ins_D(ins_D), .ins_E(ins_E), .rs_E(rs_E), .rt_E(rt_E),
                .start(start), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo);
    ins_E = ins; rs_E = a; rt_E = b; ins_D = MFLO;
    #1;
    chk("start", {31'd0, start}, 32'd1);
    chk("stall_start", {31'd0, stall_md}, 32'd1);
    tick();
    ins_E = NOP;
    #1;
    for (int i = 0; i < n; i++) begin
      chk("busy", {31'd0, busy}, 32'd1);
      chk("stall_busy", {31'd0, stall_md}, 32'd1);
      chk("start_busy", {31'd0, start}, 32'd0);
      tick();
    end
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("stall_end", {31'd0, stall_md}, 32'd0);
    chk("hi", hi, ehi);
    chk("lo", lo, elo);
    ins_D = NOP;
  endtask
  initial begin
    reset = 1'b1; ins_D = NOP; ins_E = MTHI; rs_E = 32'd77; rt_E = 32'd0;
    tick(); tick();
    chk("rst_hi_over_mthi", hi, 32'd0);
    ins_E = NOP;
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_lo", lo, 32'd0);
    ins_E = 32'h0400_0018;
    #1;
    chk("nonmd_start", {31'd0, start}, 32'd0);
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op(MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    ins_E = MTHI; rs_E = 32'h1234_5678;
    tick();
    chk("mthi_idle", hi, 32'h1234_5678);
    ins_E = MTLO; rs_E = 32'd55;
    tick();
    chk("mtlo_idle", lo, 32'd55);
    chk("mtlo_keeps_hi", hi, 32'h1234_5678);
    ins_E = MULT; rs_E = 32'd4; rt_E = 32'd4;
    tick();
    ins_E = MTHI; rs_E = 32'hDEAD_BEEF;
    tick();
    chk("mthi_busy", hi, 32'h1234_5678);
    ins_E = MULT; rs_E = 32'd9; rt_E = 32'd9;
    tick();
    ins_E = NOP;
    repeat (3) tick();
    chk("busy_ignore_done", {31'd0, busy}, 32'd0);
    chk("busy_ignore_hi", hi, 32'd0);
    chk("busy_ignore_lo", lo, 32'd16);
    ins_E = MULT; rs_E = 32'd4; rt_E = 32'd4;
    tick();
    ins_E = NOP;
    tick(); tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (8) tick();
    chk("no_commit_lo", lo, 32'd0);
    chk("no_commit_busy", {31'd0, busy}, 32'd0);
`ifdef MDU_DIV_EN
    run_op(DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    ins_E = MTHI; rs_E = 32'd5;
    tick();
    ins_E = MTLO; rs_E = 32'd9;
    tick();
    run_op(DIV, 32'd123, 32'd0, 10, 32'd5, 32'd9);
`else
    ins_E = MTHI; rs_E = 32'd5;
    tick();
    ins_E = MTLO; rs_E = 32'd9;
    tick();
    ins_E = DIV; rs_E = 32'd100; rt_E = 32'd7; ins_D = MFHI;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nodiv_start", {31'd0, start}, 32'd0);
      chk("nodiv_busy", {31'd0, busy}, 32'd0);
      chk("nodiv_stall", {31'd0, stall_md}, 32'd0);
      tick();
    end
    ins_E = DIVU;
    tick(); tick();
    chk("nodivu_busy", {31'd0, busy}, 32'd0);
    chk("nodiv_hi", hi, 32'd5);
    chk("nodiv_lo", lo, 32'd9);
    ins_E = NOP; ins_D = NOP;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
